// File: rtl/iq_byte_unpack.sv
// iq_byte_unpack: assembles little-endian I_lo, I_hi, Q_lo, Q_hi byte groups from the
// input byte FIFO into quantized signed I/Q pairs, written together to the I and Q FIFOs.
module iq_byte_unpack #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BITS        = 10,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             in_dout,
    input  logic                   in_empty,
    output logic                   in_rd_en,
    output logic [DATA_WIDTH-1:0]  i_out,
    output logic                   i_wr_en,
    input  logic                   i_full,
    output logic [DATA_WIDTH-1:0]  q_out,
    output logic                   q_wr_en,
    input  logic                   q_full,
    output logic [COUNT_WIDTH-1:0] pair_count
);

    typedef enum logic [2:0] {
        StILo,
        StIHi,
        StQLo,
        StQHi,
        StWrite
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             i_lo_q, i_hi_q, q_lo_q;
    logic [DATA_WIDTH-1:0]  i_out_q, q_out_q;
    logic [COUNT_WIDTH-1:0] pair_count_q;

    // Sign-extend a 16-bit sample to DATA_WIDTH, then shift left; overflow simply truncates.
    function automatic logic [DATA_WIDTH-1:0] quantize(input logic [15:0] sample);
        logic [DATA_WIDTH-1:0] ext;
        ext = DATA_WIDTH'($signed(sample));
        return ext << BITS;
    endfunction

    // Next-state and strobes: read one byte per byte state, then write both FIFOs at once.
    always_comb begin
        state_d  = state_q;
        in_rd_en = 1'b0;
        i_wr_en  = 1'b0;
        q_wr_en  = 1'b0;
        // Strobes are held low for the whole time reset is asserted.
        if (!reset) begin
            unique case (state_q)
                StILo: begin
                    if (!in_empty) begin
                        in_rd_en = 1'b1;
                        state_d  = StIHi;
                    end
                end
                StIHi: begin
                    if (!in_empty) begin
                        in_rd_en = 1'b1;
                        state_d  = StQLo;
                    end
                end
                StQLo: begin
                    if (!in_empty) begin
                        in_rd_en = 1'b1;
                        state_d  = StQHi;
                    end
                end
                StQHi: begin
                    if (!in_empty) begin
                        in_rd_en = 1'b1;
                        state_d  = StWrite;
                    end
                end
                StWrite: begin
                    // No read-ahead: the next group waits until this pair is written.
                    if (!i_full && !q_full) begin
                        i_wr_en = 1'b1;
                        q_wr_en = 1'b1;
                        state_d = StILo;
                    end
                end
                default: state_d = StILo;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StILo;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte capture; Q_hi is not stored, it feeds the quantized outputs directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_lo_q  <= '0;
            i_hi_q  <= '0;
            q_lo_q  <= '0;
            i_out_q <= '0;
            q_out_q <= '0;
        end else if (in_rd_en) begin
            unique case (state_q)
                StILo: i_lo_q <= in_dout;
                StIHi: i_hi_q <= in_dout;
                StQLo: q_lo_q <= in_dout;
                StQHi: begin
                    i_out_q <= quantize({i_hi_q, i_lo_q});
                    q_out_q <= quantize({in_dout, q_lo_q});
                end
                default: ;
            endcase
        end
    end

    // Pair counter, wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pair_count_q <= '0;
        end else if (i_wr_en) begin
            pair_count_q <= pair_count_q + COUNT_WIDTH'(1);
        end
    end

    assign i_out      = i_out_q;
    assign q_out      = q_out_q;
    assign pair_count = pair_count_q;

endmodule

// File: doc/iq_byte_unpack.md
Name: iq_byte_unpack

Overview:
- First stage of the FM receive chain, ahead of the complex channel FIR.
- Pulls the raw little-endian byte stream from the input byte FIFO.
- Assembles each 4-byte group into one signed 16-bit I sample and one signed 16-bit Q sample.
- Quantizes both samples (sign-extend, shift left by BITS) and writes them as a pair into the I and Q FIFOs that feed the filter.

Parameters:
DATA_WIDTH, 32, width of quantized I/Q output words
BITS, 10, quantization left-shift applied to each sign-extended 16-bit sample
COUNT_WIDTH, 32, width of the emitted-pair counter

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-high
in_dout  input  8  byte from input FIFO; first-word-fall-through, valid whenever in_empty=0
in_empty  input  1  input FIFO empty
in_rd_en  output  1  pop input FIFO; byte consumed in the same cycle
i_out  output  DATA_WIDTH  quantized I sample
i_wr_en  output  1  write strobe to I FIFO
i_full  input  1  I FIFO full
q_out  output  DATA_WIDTH  quantized Q sample
q_wr_en  output  1  write strobe to Q FIFO
q_full  input  1  Q FIFO full
pair_count  output  COUNT_WIDTH  number of I/Q pairs written since reset

Behaviour:
- Byte order per group: I_lo, I_hi, Q_lo, Q_hi.
  - I = {I_hi, I_lo}, signed 16-bit.
  - Q = {Q_hi, Q_lo}, signed 16-bit.
- Quantize: sign-extend the 16-bit value to DATA_WIDTH, shift left BITS, truncate to DATA_WIDTH. No saturation.
- FSM states: S_I_LO, S_I_HI, S_Q_LO, S_Q_HI, S_WRITE.
- In each byte state:
  - in_rd_en = !in_empty (combinational).
  - When in_empty=0: capture in_dout into that byte's register and advance to the next state.
  - When in_empty=1: hold state; no read.
- S_Q_HI on a capture goes to S_WRITE.
- In S_WRITE:
  - in_rd_en = 0.
  - When i_full=0 AND q_full=0: assert i_wr_en=1 and q_wr_en=1 in the same cycle, increment pair_count, go to S_I_LO.
  - Otherwise hold; both strobes stay 0.
  - I and Q are never written independently.
- i_wr_en and q_wr_en are combinational from state and full flags; never asserted outside S_WRITE.
- i_out and q_out are driven continuously from registered quantized values. They are updated on the cycle the Q_hi byte is captured (I is quantized from the held I_lo/I_hi), so they are stable throughout S_WRITE. Between writes they hold the last values.
- Throughput: 5 cycles per pair at best (4 reads + 1 write). A pair is written one cycle after the Q_hi byte is read.
- pair_count wraps modulo 2^COUNT_WIDTH.
- Reset (asynchronous, any state):
  - State goes to S_I_LO.
  - Byte registers, i_out, q_out and pair_count clear to 0.
  - in_rd_en, i_wr_en and q_wr_en are 0 while reset is asserted.
  - A partially assembled group is discarded. After release, the next byte read is treated as I_lo.
- Simultaneous in_empty deassertion and S_WRITE stall: no read occurs until the write completes (no read-ahead).

Test Plan:
- Bytes 0x34,0x12,0xCD,0xAB with FIFOs never full -> single write with i_out=0x0048D000, q_out=0xFEAF3400; pair_count=1; write exactly 1 cycle after the 4th read.
- Extremes: I=0x8000, Q=0x7FFF (bytes 00,80,FF,7F) -> i_out=0xFE000000, q_out=0x01FFFC00; I=0xFFFF, Q=0x0000 -> i_out=0xFFFFFC00, q_out=0x00000000.
- in_empty=1 for 7 cycles between byte 2 and byte 3 -> no in_rd_en during the gap; resulting values identical to the unstalled case; pair written once.
- In S_WRITE: i_full=1, q_full=0 for 5 cycles, then both 0 -> no strobes and no reads for 5 cycles; both strobes together on cycle 6 with unchanged data.
- 100 back-to-back random groups with random empty/full toggling -> output sequence matches the reference model exactly; pair_count=100; i_wr_en==q_wr_en on every cycle.
- Reset asserted after 3 bytes of a group, then bytes 0x01,0x00,0x02,0x00 -> outputs 0 during reset; next pair i_out=0x00000400, q_out=0x00000800; pair_count=1.
